// File: rtl/fsb_cycle_ctrl_if.sv
// rtl/fsb_cycle_ctrl_if.sv - bus-cycle handshake signals between CPU-side glue and the cycle controller
interface fsb_cycle_ctrl_if;
  logic ASActive;
  logic RAMCS;
  logic ROMCS;
  logic IOCS;
  logic IACS;
  logic IOACK;
  logic IOREQ;
  logic DTACK;
  logic BERR;
  logic Busy;

  modport master (
    output ASActive, RAMCS, ROMCS, IOCS, IACS, IOACK,
    input  IOREQ, DTACK, BERR, Busy
  );

  modport slave (
    input  ASActive, RAMCS, ROMCS, IOCS, IACS, IOACK,
    output IOREQ, DTACK, BERR, Busy
  );
endinterface

// File: rtl/fsb_cycle_ctrl.sv
// rtl/fsb_cycle_ctrl.sv - bus cycle terminator: RAM/ROM wait states, I/O four-phase handshake
// Optional bus-error timeout on I/O and unmapped cycles: FSB_BERR_TIMEOUT_EN.
module fsb_cycle_ctrl #(
  parameter int unsigned RAM_WS  = 1,
  parameter int unsigned ROM_WS  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             CLK,
  input logic             RES,
  fsb_cycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT, IOWAIT, UNMAP, TERM, DRAIN} state_t;

  localparam logic [3:0] RAM_LOAD = 4'(RAM_WS);
  localparam logic [3:0] ROM_LOAD = 4'(ROM_WS);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       ack_meta, ackS;
  logic       dtack_q, dtack_nx;
  logic       berr_q, berr_nx;
  logic       ioreq_q, ioreq_nx;
  logic       timeout_hit;

  // IOACK comes from a foreign clock domain
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ack_meta <= 1'b0;
      ackS     <= 1'b0;
    end else begin
      ack_meta <= bus.IOACK;
      ackS     <= ack_meta;
    end
  end

`ifdef FSB_BERR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tcnt;

  // Cleared on every state change, so it restarts on IOWAIT/UNMAP entry
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      tcnt <= '0;
    end else if (state_nx != state) begin
      tcnt <= '0;
    end else if (state == IOWAIT || state == UNMAP) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  assign timeout_hit = (tcnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state   <= IDLE;
      cnt     <= '0;
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;
      ioreq_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      dtack_q <= dtack_nx;
      berr_q  <= berr_nx;
      ioreq_q <= ioreq_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dtack_nx = dtack_q;
    berr_nx  = berr_q;
    ioreq_nx = ioreq_q;
    unique case (state)
      IDLE: begin
        if (bus.ASActive) begin
          if (bus.IOCS || bus.IACS) begin
            // A still-high synchronised ack means the last handshake has not finished
            if (!ackS) begin
              state_nx = IOWAIT;
              ioreq_nx = 1'b1;
            end
          end else if (bus.ROMCS) begin
            state_nx = WAIT;
            cnt_nx   = ROM_LOAD;
          end else if (bus.RAMCS) begin
            state_nx = WAIT;
            cnt_nx   = RAM_LOAD;
          end else begin
            state_nx = UNMAP;
          end
        end
      end
      WAIT: begin
        if (!bus.ASActive) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          state_nx = TERM;
          dtack_nx = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      IOWAIT: begin
        if (!bus.ASActive) begin
          state_nx = DRAIN;
        end else if (ackS) begin
          state_nx = TERM;
          ioreq_nx = 1'b0;
          dtack_nx = 1'b1;
        end else if (timeout_hit) begin
          state_nx = TERM;
          ioreq_nx = 1'b0;
          berr_nx  = 1'b1;
        end
      end
      UNMAP: begin
        if (!bus.ASActive) begin
          state_nx = IDLE;
        end else if (timeout_hit) begin
          state_nx = TERM;
          berr_nx  = 1'b1;
        end
      end
      TERM: begin
        if (!bus.ASActive) begin
          state_nx = IDLE;
          dtack_nx = 1'b0;
          berr_nx  = 1'b0;
        end
      end
      DRAIN: begin
        // Aborted I/O cycle: finish the handshake silently
        if (ackS) begin
          state_nx = IDLE;
          ioreq_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        dtack_nx = 1'b0;
        berr_nx  = 1'b0;
        ioreq_nx = 1'b0;
      end
    endcase
  end

  assign bus.DTACK = dtack_q;
  assign bus.BERR  = berr_q;
  assign bus.IOREQ = ioreq_q;
  assign bus.Busy  = (state != IDLE);

endmodule

// File: tb/tb_fsb_cycle_ctrl.sv
// tb/tb_fsb_cycle_ctrl.sv - vector table plus directed sequences for fsb_cycle_ctrl
module tb_fsb_cycle_ctrl;

  logic CLK;
  logic RES;
  logic as_i, ram_i, rom_i, io_i, ia_i, ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  fsb_cycle_ctrl_if bus0 ();
  fsb_cycle_ctrl_if bus1 ();

  assign bus0.ASActive = as_i;
  assign bus0.RAMCS    = ram_i;
  assign bus0.ROMCS    = rom_i;
  assign bus0.IOCS     = io_i;
  assign bus0.IACS     = ia_i;
  assign bus0.IOACK    = ack_i;
  assign bus1.ASActive = as_i;
  assign bus1.RAMCS    = ram_i;
  assign bus1.ROMCS    = rom_i;
  assign bus1.IOCS     = io_i;
  assign bus1.IACS     = ia_i;
  assign bus1.IOACK    = ack_i;

  // dut0: RAM 1 wait state, ROM 0 wait states; dut1: RAM 15 wait states
  fsb_cycle_ctrl #(.RAM_WS(1), .ROM_WS(0), .TIMEOUT(255)) dut0 (
    .CLK(CLK), .RES(RES), .bus(bus0)
  );
  fsb_cycle_ctrl #(.RAM_WS(15), .ROM_WS(2), .TIMEOUT(255)) dut1 (
    .CLK(CLK), .RES(RES), .bus(bus1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0] stim;  // {as, ram, rom, io, ia, ack}
    logic [3:0] expv;  // {DTACK, BERR, IOREQ, Busy}
  } vec_t;

  localparam int NV = 43;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [5:0] s);
    {as_i, ram_i, rom_i, io_i, ia_i, ack_i} = s;
  endtask

  always @(negedge CLK) begin
    if (!RES && bus0.DTACK && bus0.BERR) begin
      n_fail++;
      $display("FAIL dtack_berr_excl: both high");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, first_berr;
    bit dtack_seen;

    vecs[0]  = '{6'b110000, 4'b0001};
    vecs[1]  = '{6'b110000, 4'b0001};
    vecs[2]  = '{6'b110000, 4'b1001};
    vecs[3]  = '{6'b110000, 4'b1001};
    vecs[4]  = '{6'b000000, 4'b0000};
    vecs[5]  = '{6'b101000, 4'b0001};
    vecs[6]  = '{6'b101000, 4'b1001};
    vecs[7]  = '{6'b000000, 4'b0000};
    vecs[8]  = '{6'b110100, 4'b0011};
    vecs[9]  = '{6'b110100, 4'b0011};
    vecs[10] = '{6'b110100, 4'b0011};
    vecs[11] = '{6'b110101, 4'b0011};
    vecs[12] = '{6'b110101, 4'b0011};
    vecs[13] = '{6'b110101, 4'b1001};
    vecs[14] = '{6'b000001, 4'b0000};
    vecs[15] = '{6'b100101, 4'b0000};
    vecs[16] = '{6'b100100, 4'b0000};
    vecs[17] = '{6'b100100, 4'b0000};
    vecs[18] = '{6'b100100, 4'b0011};
    vecs[19] = '{6'b000000, 4'b0011};
    vecs[20] = '{6'b000001, 4'b0011};
    vecs[21] = '{6'b000001, 4'b0011};
    vecs[22] = '{6'b000001, 4'b0000};
    vecs[23] = '{6'b000000, 4'b0000};
    vecs[24] = '{6'b000000, 4'b0000};
    vecs[25] = '{6'b000000, 4'b0000};
    vecs[26] = '{6'b100010, 4'b0011};
    vecs[27] = '{6'b100001, 4'b0011};
    vecs[28] = '{6'b100001, 4'b0011};
    vecs[29] = '{6'b100001, 4'b1001};
    vecs[30] = '{6'b000000, 4'b0000};
    vecs[31] = '{6'b000000, 4'b0000};
    vecs[32] = '{6'b000000, 4'b0000};
    vecs[33] = '{6'b111000, 4'b0001};
    vecs[34] = '{6'b111000, 4'b1001};
    vecs[35] = '{6'b000000, 4'b0000};
    vecs[36] = '{6'b110000, 4'b0001};
    vecs[37] = '{6'b000000, 4'b0000};
    vecs[38] = '{6'b000000, 4'b0000};
    vecs[39] = '{6'b110000, 4'b0001};
    vecs[40] = '{6'b100100, 4'b0001};
    vecs[41] = '{6'b100100, 4'b1001};
    vecs[42] = '{6'b000000, 4'b0000};

    // Asynchronous reset takes effect before any clock edge
    drive(6'b000000);
    RES = 1'b0;
    #1 RES = 1'b1;
    #2;
    check("reset_outs0", {bus0.DTACK, bus0.BERR, bus0.IOREQ, bus0.Busy}, 4'b0000);
    check("reset_outs1", {bus1.DTACK, bus1.BERR, bus1.IOREQ, bus1.Busy}, 4'b0000);
    cyc();
    cyc();
    RES = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stim);
      cyc();
      check($sformatf("vec%0d", i), {bus0.DTACK, bus0.BERR, bus0.IOREQ, bus0.Busy}, vecs[i].expv);
    end

    // Reset in the middle of a long wait-state cycle
    drive(6'b110000);
    for (int i = 0; i < 5; i++) cyc();
    check("pre_rst_busy1", bus1.Busy, 1'b1);
    #2 RES = 1'b1;
    #1;
    check("midrst_outs1", {bus1.DTACK, bus1.BERR, bus1.IOREQ, bus1.Busy}, 4'b0000);
    check("midrst_outs0", {bus0.DTACK, bus0.BERR, bus0.IOREQ, bus0.Busy}, 4'b0000);
    drive(6'b000000);
    cyc();
    RES = 1'b0;
    cyc();

    drive(6'b110000);
    lat0 = 0;
    lat1 = 0;
    for (int n = 1; n <= 40 && lat1 == 0; n++) begin
      cyc();
      if (lat0 == 0 && bus0.DTACK) lat0 = n;
      if (bus1.DTACK) lat1 = n;
    end
    check("ws15_latency", lat1, 17);
    check("ws1_latency", lat0, 3);
    drive(6'b000000);
    cyc();
    check("ws15_release", {bus1.DTACK, bus1.Busy}, 2'b00);

    // Reset while an I/O handshake is in flight
    drive(6'b100100);
    cyc();
    check("io_req_up", bus0.IOREQ, 1'b1);
    #2 RES = 1'b1;
    #1;
    check("io_rst_clear", {bus0.IOREQ, bus0.Busy}, 2'b00);
    drive(6'b000000);
    cyc();
    RES = 1'b0;
    cyc();

    // Unmapped cycle aborted by the strobe falling
    drive(6'b100000);
    cyc();
    check("unmap_busy", {bus0.DTACK, bus0.Busy}, 2'b01);
    cyc();
    drive(6'b000000);
    cyc();
    check("unmap_abort", {bus0.DTACK, bus0.BERR, bus0.Busy}, 3'b000);

    // Unmapped cycle left running: bus error only with the timeout build
    drive(6'b100000);
    cyc();
    first_berr = 0;
    dtack_seen = 1'b0;
    for (int j = 1; j <= 260; j++) begin
      cyc();
      if (bus0.DTACK) dtack_seen = 1'b1;
      if (first_berr == 0 && bus0.BERR) first_berr = j;
    end
`ifdef FSB_BERR_TIMEOUT_EN
    check("unmap_berr_time", first_berr, 255);
`else
    check("unmap_no_berr", first_berr, 0);
    check("unmap_still_busy", bus0.Busy, 1'b1);
`endif
    check("unmap_no_dtack", dtack_seen, 1'b0);
    drive(6'b000000);
    cyc();
    check("unmap_end", {bus0.DTACK, bus0.BERR, bus0.Busy}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsb_cycle_ctrl.md
FSB_CYCLE_CTRL -- requirements
Module: fsb_cycle_ctrl

Interface
REQ-001 SHALL provide parameter RAM_WS, default 1, RAM wait states (0-15).
REQ-002 SHALL provide parameter ROM_WS, default 2, ROM wait states (0-15).
REQ-003 SHALL provide parameter TIMEOUT, default 255, cycles before bus error (1-255).
REQ-004 SHALL provide port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port RES  in  1  reset; asynchronous and active-high.
REQ-006 SHALL provide port ASActive  in  1  qualified address strobe; high for the whole bus cycle.
REQ-007 SHALL provide ports RAMCS, ROMCS, IOCS, IACS  in  1 each  decoded device selects, valid while ASActive.
REQ-008 SHALL provide port IOACK  in  1  I/O-bus acknowledge; asynchronous to CLK.
REQ-009 SHALL provide port IOREQ  out  1  I/O-bus request; four-phase handshake with IOACK.
REQ-010 SHALL provide port DTACK  out  1  normal cycle termination; active-high.
REQ-011 SHALL provide port BERR  out  1  bus-error termination; active-high.
REQ-012 SHALL provide port Busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL synchronise IOACK through two flip-flops; "ackS" is the second stage.
REQ-014 SHALL use the states IDLE, WAIT, IOWAIT, UNMAP, TERM and DRAIN.
REQ-015 In IDLE, when ASActive=1, SHALL select the path with priority (IOCS|IACS) > ROMCS > RAMCS > none.
- The IOCS+RAMCS overlap (video-RAM write) takes the I/O path.
REQ-016 RAM/ROM path: SHALL load the 4-bit counter with RAM_WS/ROM_WS and enter WAIT.
REQ-017 In WAIT, SHALL decrement the counter each cycle and enter TERM when the counter is 0.
- Latency: ASActive sampled at edge k gives DTACK high after edge k+1+WS.
- WS=0 therefore gives DTACK after edge k+1.
REQ-018 I/O path: SHALL enter IOWAIT with IOREQ=1 only if ackS=0.
- While ackS=1, SHALL remain in IDLE; the previous handshake is not yet complete.
REQ-019 In IOWAIT, on ackS=1, SHALL set IOREQ=0 and enter TERM with DTACK=1.
REQ-020 No select asserted: SHALL enter UNMAP; no DTACK is ever generated from UNMAP.
REQ-021 In TERM, SHALL hold DTACK (or BERR) high until ASActive=0.
- On that edge, outputs clear and the state returns to IDLE.
REQ-022 ASActive falling in WAIT or UNMAP (aborted cycle): SHALL return to IDLE on the next edge without asserting DTACK.
REQ-023 ASActive falling in IOWAIT: SHALL enter DRAIN.
- DRAIN keeps IOREQ=1 until ackS=1, then drops IOREQ and returns to IDLE.
- No termination is driven from DRAIN.
REQ-024 DTACK and BERR SHALL never be high in the same cycle.
REQ-025 IOREQ SHALL never be high outside IOWAIT and DRAIN.
REQ-026 Selects SHALL be sampled only on the IDLE exit edge; later changes on the selects are ignored.

Reset
REQ-027 While RES=1, the block SHALL immediately force:
- state IDLE;
- IOREQ, DTACK, BERR and Busy at 0;
- counters and synchroniser flops at 0.
REQ-028 RES asserted mid-cycle (including mid-handshake) SHALL abandon the cycle; after release, the block restarts in IDLE.

Configuration
REQ-029 With macro FSB_BERR_TIMEOUT_EN defined, SHALL count the cycles spent in IOWAIT or UNMAP with an 8-bit counter cleared on entry.
- When the count reaches TIMEOUT: enter TERM with BERR=1, DTACK=0, IOREQ=0.
- A late IOACK is then absorbed by the ackS check in REQ-018.
REQ-030 Without FSB_BERR_TIMEOUT_EN, SHALL implement no timeout counter.
- BERR is tied to 0.
- UNMAP and IOWAIT wait indefinitely, until ASActive falls or IOACK arrives.

Verification
REQ-031 RAMCS=1, ASActive rises at edge 0, RAM_WS=1 -> DTACK=1 after edge 2; DTACK=0 on the edge where ASActive=0 is sampled.
REQ-032 ROMCS=1 with ROM_WS=0 -> DTACK after edge 1; Busy=1 from edge 1 until ASActive falls.
REQ-033 IOCS=1 and RAMCS=1 together -> IOREQ=1, no DTACK.
- IOACK driven high 3 cycles later -> IOREQ=0 and DTACK=1 two to three edges after it.
- Next I/O cycle is held in IDLE until IOACK low is synchronised.
REQ-034 IOCS=1, ASActive dropped while IOREQ=1 -> DRAIN.
- IOREQ stays 1 until IOACK, then 0; DTACK stays 0 throughout.
REQ-035 No select, FSB_BERR_TIMEOUT_EN defined, TIMEOUT=255 -> BERR=1 exactly 255 cycles after UNMAP entry, DTACK=0; same stimulus without the macro -> no termination.
REQ-036 RES pulsed during WAIT with WS=15 -> all outputs 0 immediately; a following RAMCS cycle terminates normally.
